osd_wr_scheduler: RTL

Schedules writes into the OSD text/attribute RAM in the N64 video clock domain so they land only inside a vertical-blanking window derived from the N64 sync stream. Arbitrates the single OSD write port between two requesters: the CPU write vector (already resynced into N64_CLK_i) and a hardware status-overlay writer. Uses round-robin with a burst limit and enforces a minimum spacing between writes. Sits between the controller's OSD write vector and the OSD RAM write port in the video pipeline.

---
 rtl/osd_wr_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/osd_wr_scheduler.sv
// osd_wr_scheduler
// Arbitrates the single OSD RAM write port between the CPU write vector and
// the hardware status-overlay writer. Writes are only issued inside a
// vertical-blanking window that opens on the falling edge of the captured
// vsync bit and closes after WIN_LINES captured hsync falls. Both requesters
// are served round-robin. A run that began while the requester was alone may
// extend up to MAX_BURST grants once the other requester turns up. Write
// strobes are spaced at least WR_SPACING cycles apart.
module osd_wr_scheduler #(
  parameter logic [9:0] WIN_LINES  = 10'd16,  // 1..1023
  parameter logic [3:0] MAX_BURST  = 4'd8,    // 1..15
  parameter logic [2:0] WR_SPACING = 3'd4     // 1..7
) (
  input  logic        N64_CLK_i,
  input  logic        CTRL_nRST,
  input  logic        nVDSYNC_i,
  input  logic        VD_VS_i,
  input  logic        VD_HS_i,
  input  logic        cpu_req_i,
  input  logic [19:0] cpu_data_i,
  output logic        cpu_ack_o,
  input  logic        hw_req_i,
  input  logic [19:0] hw_data_i,
  output logic        hw_ack_o,
  output logic        osd_wr_en_o,
  output logic [19:0] osd_wr_data_o,
  output logic        window_o
);

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'b00,
    ST_WINDOW  = 2'b01
  } state_t;

  typedef enum logic {
    REQ_HW  = 1'b0,
    REQ_CPU = 1'b1
  } req_id_t;

  localparam logic [2:0] SPACE_RELOAD = WR_SPACING - 3'd1;

  // sync capture
  logic vs_buf, hs_buf, vs_buf_d, hs_buf_d;
  logic vs_fall, hs_fall;

  // window FSM
  state_t     state, state_nxt;
  logic [9:0] line_cnt, line_nxt;

  // arbitration
  logic [2:0] space_cnt;
  logic [3:0] burst_cnt;
  req_id_t    last_grant;
  logic       run_open;   // current run started while its requester was alone
  logic       gnt_valid;
  req_id_t    gnt_id;
  logic       both_req;

  // Capture the sync bits only while a sync byte is on the bus; keep the
  // previous value so a single-cycle falling edge can be detected.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      vs_buf   <= 1'b1;
      hs_buf   <= 1'b1;
      vs_buf_d <= 1'b1;
      hs_buf_d <= 1'b1;
    end else begin
      if (!nVDSYNC_i) begin
        vs_buf <= VD_VS_i;
        hs_buf <= VD_HS_i;
      end
      vs_buf_d <= vs_buf;
      hs_buf_d <= hs_buf;
    end
  end

  assign vs_fall = vs_buf_d & ~vs_buf;
  assign hs_fall = hs_buf_d & ~hs_buf;

  // Window state and line counter registers.
  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      state    <= ST_WAIT_VS;
      line_cnt <= 10'd0;
    end else begin
      state    <= state_nxt;
      line_cnt <= line_nxt;
    end
  end

  // Window next-state: vsync restarts the window, hsync counts lines.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    line_nxt  = line_cnt;
    case (state)
      ST_WAIT_VS: begin
        if (vs_fall) begin
          line_nxt  = 10'd0;
          state_nxt = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        if (vs_fall) begin
          line_nxt = 10'd0;
        end else if (hs_fall) begin
          if (line_cnt + 10'd1 == WIN_LINES) begin
            state_nxt = ST_WAIT_VS;
            line_nxt  = 10'd0;
          end else begin
            line_nxt = line_cnt + 10'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_WAIT_VS;
        line_nxt  = 10'd0;
      end
    endcase
  end

  assign window_o = (state == ST_WINDOW);
  assign both_req = cpu_req_i & hw_req_i;

  // Grant decision; uses the next window state so the first grant can land
  // in the same cycle the window opens, and none lands on the closing edge.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = REQ_CPU;
    if (state_nxt == ST_WINDOW && space_cnt == 3'd0) begin
      if (both_req) begin
        gnt_valid = 1'b1;
        if (run_open && burst_cnt < MAX_BURST) begin
          gnt_id = last_grant;
        end else begin
          gnt_id = (last_grant == REQ_CPU) ? REQ_HW : REQ_CPU;
        end
      end else if (cpu_req_i) begin
        gnt_valid = 1'b1;
        gnt_id    = REQ_CPU;
      end else if (hw_req_i) begin
        gnt_valid = 1'b1;
        gnt_id    = REQ_HW;
      end
    end
  end

  // Registered write strobe, data and ack pulses.
  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      osd_wr_en_o   <= 1'b0;
      osd_wr_data_o <= 20'h0;
      cpu_ack_o     <= 1'b0;
      hw_ack_o      <= 1'b0;
    end else begin
      osd_wr_en_o <= gnt_valid;
      cpu_ack_o   <= gnt_valid && (gnt_id == REQ_CPU);
      hw_ack_o    <= gnt_valid && (gnt_id == REQ_HW);
      if (gnt_valid) begin
        osd_wr_data_o <= (gnt_id == REQ_CPU) ? cpu_data_i : hw_data_i;
      end
    end
  end

  // Spacing counter, burst counter and round-robin history.
  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      space_cnt  <= 3'd0;
      burst_cnt  <= 4'd0;
      last_grant <= REQ_HW;
      run_open   <= 1'b0;
    end else begin
      if (gnt_valid) begin
        space_cnt  <= SPACE_RELOAD;
        last_grant <= gnt_id;
        if (gnt_id == last_grant) begin
          if (burst_cnt != 4'd15) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
          run_open <= run_open | ~both_req;
        end else begin
          burst_cnt <= 4'd1;
          run_open  <= ~both_req;
        end
      end else if (space_cnt != 3'd0) begin
        space_cnt <= space_cnt - 3'd1;
      end
    end
  end

endmodule
